// File: rtl/unified_memory_arbiter.sv
// Arbiter sharing one single-ported memory between the fetch port and the load/store port.
// Define ARB_ROUND_ROBIN_EN to replace the data-priority/starvation rule with alternating grants.
module unified_memory_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchRequest,
  input  logic [31:0] fetchAddress,
  input  logic        fetchCancel,
  output logic [31:0] fetchData,
  output logic        fetchDataValid,
  input  logic        dataRequest,
  input  logic        dataWrite,
  input  logic [31:0] dataAddress,
  input  logic [31:0] dataStoreData,
  input  logic [3:0]  dataByteEnable,
  output logic [31:0] loadData,
  output logic        loadDataValid,
  output logic        storeComplete,
  output logic        accessFault,
  output logic        accessFaultData,
  output logic        memRequest,
  output logic [31:0] memAddress,
  output logic        memWriteEnable,
  output logic [31:0] memWriteData,
  output logic [3:0]  memByteEnable,
  input  logic [31:0] memReadData,
  input  logic        memResponseValid
);

  typedef enum logic [1:0] {IDLE, FETCH_WAIT, DATA_WAIT} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [TW-1:0] timeout_count;
  logic          cancelled;
  logic          is_store;
  logic          fetch_ok;
  logic          fetch_wins;
  logic          grant_fetch;
  logic          grant_data;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_data;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_count;
`endif

  assign fetch_ok = fetchRequest & ~fetchCancel;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    fetch_wins = ~dataRequest | last_grant_data;
`else
    fetch_wins = ~dataRequest | (starve_count == STARVE_MAX);
`endif
    grant_fetch = fetch_ok & fetch_wins;
    grant_data  = dataRequest & ~grant_fetch;
  end

  // Responses are forwarded in the cycle they arrive; a cancel in that same cycle drops the fetch word.
  always_comb begin
    fetchData      = '0;
    fetchDataValid = 1'b0;
    loadData       = '0;
    loadDataValid  = 1'b0;
    storeComplete  = 1'b0;
    if (!reset && memResponseValid) begin
      case (state)
        FETCH_WAIT: begin
          fetchData      = memReadData;
          fetchDataValid = ~cancelled & ~fetchCancel;
        end
        DATA_WAIT: begin
          if (is_store) begin
            storeComplete = 1'b1;
          end else begin
            loadData      = memReadData;
            loadDataValid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      timeout_count   <= '0;
      cancelled       <= 1'b0;
      is_store        <= 1'b0;
      accessFault     <= 1'b0;
      accessFaultData <= 1'b0;
      memRequest      <= 1'b0;
      memAddress      <= '0;
      memWriteEnable  <= 1'b0;
      memWriteData    <= '0;
      memByteEnable   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_data <= 1'b0;
`else
      starve_count    <= '0;
`endif
    end else begin
      memRequest      <= 1'b0;
      accessFault     <= 1'b0;
      accessFaultData <= 1'b0;
      case (state)
        IDLE: begin
          cancelled     <= 1'b0;
          timeout_count <= '0;
          if (grant_fetch) begin
            memRequest     <= 1'b1;
            memAddress     <= fetchAddress;
            memWriteEnable <= 1'b0;
            memWriteData   <= '0;
            memByteEnable  <= 4'hF;
            state          <= FETCH_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_data <= 1'b0;
`else
            starve_count    <= '0;
`endif
          end else if (grant_data) begin
            memRequest     <= 1'b1;
            memAddress     <= dataAddress;
            memWriteEnable <= dataWrite;
            memWriteData   <= dataWrite ? dataStoreData : 32'h0;
            memByteEnable  <= dataWrite ? dataByteEnable : 4'hF;
            is_store       <= dataWrite;
            state          <= DATA_WAIT;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_data <= 1'b1;
`else
            if (!fetchRequest)
              starve_count <= '0;
            else if (starve_count != STARVE_MAX)
              starve_count <= starve_count + SW'(1);
`endif
          end else begin
`ifndef ARB_ROUND_ROBIN_EN
            if (!fetchRequest)
              starve_count <= '0;
`endif
          end
        end
        FETCH_WAIT, DATA_WAIT: begin
          if (state == FETCH_WAIT && fetchCancel)
            cancelled <= 1'b1;
          if (memResponseValid) begin
            state         <= IDLE;
            timeout_count <= '0;
            cancelled     <= 1'b0;
          end else if (timeout_count == TIMEOUT_LAST) begin
            // Abort: no valid/complete pulse, and a late response will land in IDLE and be ignored.
            accessFault     <= 1'b1;
            accessFaultData <= (state == DATA_WAIT);
            state           <= IDLE;
            timeout_count   <= '0;
            cancelled       <= 1'b0;
          end else begin
            timeout_count <= timeout_count + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed self-checking bench for unified_memory_arbiter with a simple delayed-response memory model.
module tb_unified_memory_arbiter;

  logic        clock;
  logic        reset;
  logic        fetchRequest;
  logic [31:0] fetchAddress;
  logic        fetchCancel;
  logic [31:0] fetchData;
  logic        fetchDataValid;
  logic        dataRequest;
  logic        dataWrite;
  logic [31:0] dataAddress;
  logic [31:0] dataStoreData;
  logic [3:0]  dataByteEnable;
  logic [31:0] loadData;
  logic        loadDataValid;
  logic        storeComplete;
  logic        accessFault;
  logic        accessFaultData;
  logic        memRequest;
  logic [31:0] memAddress;
  logic        memWriteEnable;
  logic [31:0] memWriteData;
  logic [3:0]  memByteEnable;
  logic [31:0] memReadData;
  logic        memResponseValid;

  int checks = 0;
  int errors = 0;

  logic        mem_auto;
  int          mem_delay;
  logic [31:0] mem_rdata;
  logic        inject_req;
  int          countdown;

  unified_memory_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset),
    .fetchRequest(fetchRequest), .fetchAddress(fetchAddress), .fetchCancel(fetchCancel),
    .fetchData(fetchData), .fetchDataValid(fetchDataValid),
    .dataRequest(dataRequest), .dataWrite(dataWrite), .dataAddress(dataAddress),
    .dataStoreData(dataStoreData), .dataByteEnable(dataByteEnable),
    .loadData(loadData), .loadDataValid(loadDataValid), .storeComplete(storeComplete),
    .accessFault(accessFault), .accessFaultData(accessFaultData),
    .memRequest(memRequest), .memAddress(memAddress), .memWriteEnable(memWriteEnable),
    .memWriteData(memWriteData), .memByteEnable(memByteEnable),
    .memReadData(memReadData), .memResponseValid(memResponseValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: answers mem_delay cycles after memRequest (0 = same cycle), or once per inject_req.
  always @(posedge clock) begin
    #1;
    memResponseValid = 1'b0;
    memReadData      = mem_rdata;
    if (reset) begin
      countdown = -1;
    end else begin
      if (memRequest && mem_auto)
        countdown = mem_delay;
      if (countdown == 0) begin
        memResponseValid = 1'b1;
        countdown = -1;
      end else if (countdown > 0) begin
        countdown = countdown - 1;
      end
      if (inject_req)
        memResponseValid = 1'b1;
    end
  end

  task automatic do_reset();
    reset          = 1'b1;
    fetchRequest   = 1'b0;
    fetchAddress   = '0;
    fetchCancel    = 1'b0;
    dataRequest    = 1'b0;
    dataWrite      = 1'b0;
    dataAddress    = '0;
    dataStoreData  = '0;
    dataByteEnable = '0;
    mem_auto       = 1'b0;
    mem_delay      = 0;
    inject_req     = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [138:0] outs;
    do_reset();
    reset = 1'b1;
    @(negedge clock);
    outs = {fetchData, fetchDataValid, loadData, loadDataValid, storeComplete, accessFault,
            accessFaultData, memRequest, memAddress, memWriteEnable, memWriteData, memByteEnable};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", outs);
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch();
    do_reset();
    mem_auto = 1'b1; mem_delay = 2; mem_rdata = 32'h0050_0093;
    fetchRequest = 1'b1; fetchAddress = 32'h40;
    @(negedge clock);
    checks++;
    if ({memRequest, memAddress, memByteEnable, memWriteEnable} !== {1'b1, 32'h40, 4'hF, 1'b0}) begin
      errors++;
      $display("[TB] FAIL fetch_cmd: got req=%b addr=%h be=%h we=%b expected 1 00000040 f 0",
               memRequest, memAddress, memByteEnable, memWriteEnable);
    end
    @(negedge clock);
    checks++;
    if ({memRequest, fetchDataValid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fetch_cycle2: got req=%b valid=%b expected 0 0", memRequest, fetchDataValid);
    end
    @(negedge clock);
    checks++;
    if ({fetchDataValid, fetchData} !== {1'b1, 32'h0050_0093}) begin
      errors++;
      $display("[TB] FAIL fetch_response: got valid=%b data=%h expected 1 00500093", fetchDataValid, fetchData);
    end
    fetchRequest = 1'b0;
    @(negedge clock);
    checks++;
    if ({fetchDataValid, memRequest} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL fetch_after: got valid=%b req=%b expected 0 0", fetchDataValid, memRequest);
    end
  endtask

  task automatic test_load();
    do_reset();
    mem_auto = 1'b1; mem_delay = 0; mem_rdata = 32'h1234_5678;
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h205;
    @(negedge clock);
    checks++;
    if ({memRequest, memAddress, memWriteEnable, memByteEnable, loadDataValid, loadData}
        !== {1'b1, 32'h205, 1'b0, 4'hF, 1'b1, 32'h1234_5678}) begin
      errors++;
      $display("[TB] FAIL load_zero_wait: got req=%b addr=%h we=%b be=%h valid=%b data=%h expected 1 00000205 0 f 1 12345678",
               memRequest, memAddress, memWriteEnable, memByteEnable, loadDataValid, loadData);
    end
    dataRequest = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_store();
    int pulses;
    do_reset();
    mem_auto = 1'b1; mem_delay = 1; mem_rdata = 32'hFFFF_FFFF;
    dataRequest = 1'b1; dataWrite = 1'b1; dataAddress = 32'h100;
    dataStoreData = 32'hDEAD_BEEF; dataByteEnable = 4'b0011;
    @(negedge clock);
    checks++;
    if ({memRequest, memWriteEnable, memAddress, memWriteData, memByteEnable}
        !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 4'b0011}) begin
      errors++;
      $display("[TB] FAIL store_cmd: got req=%b we=%b addr=%h wd=%h be=%b expected 1 1 00000100 deadbeef 0011",
               memRequest, memWriteEnable, memAddress, memWriteData, memByteEnable);
    end
    pulses = storeComplete ? 1 : 0;
    @(negedge clock);
    checks++;
    if ({storeComplete, loadDataValid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL store_ack: got complete=%b loadvalid=%b expected 1 0", storeComplete, loadDataValid);
    end
    pulses += storeComplete ? 1 : 0;
    dataRequest = 1'b0; dataWrite = 1'b0;
    repeat (3) begin
      @(negedge clock);
      pulses += storeComplete ? 1 : 0;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("[TB] FAIL store_pulse_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_grant_order();
    string exp_order;
    int    n;
    byte   got;
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = "DFDFDFDFDF";
`else
    exp_order = "DDDDFDDDDF";
`endif
    do_reset();
    mem_auto = 1'b1; mem_delay = 0; mem_rdata = 32'h0;
    fetchRequest = 1'b1; fetchAddress = 32'h1000;
    dataRequest  = 1'b1; dataWrite = 1'b0; dataAddress = 32'h2000;
    n = 0;
    for (int cyc = 0; cyc < 200 && n < 10; cyc++) begin
      @(negedge clock);
      if (memRequest) begin
        got = (memAddress == 32'h1000) ? "F" : "D";
        checks++;
        if (got !== exp_order[n]) begin
          errors++;
          $display("[TB] FAIL grant_order[%0d]: got %s expected %s", n, got, exp_order[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("[TB] FAIL grant_order_timeout: got %0d grants expected 10", n);
    end
    fetchRequest = 1'b0; dataRequest = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_cancel();
    do_reset();
    mem_auto = 1'b1; mem_delay = 2; mem_rdata = 32'h0000_0013;
    fetchRequest = 1'b1; fetchAddress = 32'h80;
    @(negedge clock);
    fetchCancel = 1'b1;
    @(negedge clock);
    fetchCancel = 1'b0; fetchAddress = 32'hC0;
    @(negedge clock);
    checks++;
    if ({memResponseValid, fetchDataValid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL cancel_drop: got resp=%b valid=%b expected 1 0", memResponseValid, fetchDataValid);
    end
    @(negedge clock);
    checks++;
    if (memRequest !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cancel_idle: got req=%b expected 0", memRequest);
    end
    @(negedge clock);
    checks++;
    if ({memRequest, memAddress} !== {1'b1, 32'hC0}) begin
      errors++;
      $display("[TB] FAIL cancel_regrant: got req=%b addr=%h expected 1 000000c0", memRequest, memAddress);
    end
    repeat (2) @(negedge clock);
    checks++;
    if ({fetchDataValid, fetchData} !== {1'b1, 32'h0000_0013}) begin
      errors++;
      $display("[TB] FAIL cancel_next_fetch: got valid=%b data=%h expected 1 00000013", fetchDataValid, fetchData);
    end
    fetchRequest = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_cancel_with_response();
    do_reset();
    mem_auto = 1'b1; mem_delay = 0; mem_rdata = 32'hAAAA_5555;
    fetchRequest = 1'b1; fetchAddress = 32'h44;
    @(negedge clock);
    fetchCancel = 1'b1;
    #1;
    checks++;
    if ({memResponseValid, fetchDataValid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL cancel_same_cycle: got resp=%b valid=%b expected 1 0", memResponseValid, fetchDataValid);
    end
    fetchRequest = 1'b0;
    @(negedge clock);
    fetchCancel = 1'b0;
  endtask

  task automatic test_timeout();
    int early;
    do_reset();
    mem_auto = 1'b0; mem_rdata = 32'hBAD0_BAD0;
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h300;
    @(negedge clock);
    checks++;
    if (memRequest !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_cmd: got req=%b expected 1", memRequest);
    end
    early = 0;
    repeat (63) begin
      @(negedge clock);
      if (accessFault) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got %0d fault cycles expected 0", early);
    end
    @(negedge clock);
    checks++;
    if ({accessFault, accessFaultData, loadDataValid} !== 3'b110) begin
      errors++;
      $display("[TB] FAIL timeout_fault: got fault=%b data=%b loadvalid=%b expected 1 1 0",
               accessFault, accessFaultData, loadDataValid);
    end
    dataRequest = 1'b0;
    inject_req  = 1'b1;
    @(negedge clock);
    inject_req = 1'b0;
    checks++;
    if ({memResponseValid, loadDataValid, storeComplete, fetchDataValid, accessFault, memRequest} !== 6'b100000) begin
      errors++;
      $display("[TB] FAIL late_response: got resp=%b load=%b store=%b fetch=%b fault=%b req=%b expected 1 0 0 0 0 0",
               memResponseValid, loadDataValid, storeComplete, fetchDataValid, accessFault, memRequest);
    end
  endtask

  task automatic test_reset_mid();
    logic [138:0] outs;
    do_reset();
    mem_auto = 1'b0; mem_rdata = 32'h0000_0093;
    dataRequest = 1'b1; dataWrite = 1'b0; dataAddress = 32'h400;
    repeat (3) @(negedge clock);
    reset = 1'b1; inject_req = 1'b1; dataRequest = 1'b0;
    @(negedge clock);
    outs = {fetchData, fetchDataValid, loadData, loadDataValid, storeComplete, accessFault,
            accessFaultData, memRequest, memAddress, memWriteEnable, memWriteData, memByteEnable};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got %h expected 0", outs);
    end
    reset = 1'b0; inject_req = 1'b0;
    mem_auto = 1'b1; mem_delay = 0;
    fetchRequest = 1'b1; fetchAddress = 32'h48;
    @(negedge clock);
    checks++;
    if ({memRequest, memAddress, fetchDataValid, fetchData} !== {1'b1, 32'h48, 1'b1, 32'h0000_0093}) begin
      errors++;
      $display("[TB] FAIL reset_mid_fetch: got req=%b addr=%h valid=%b data=%h expected 1 00000048 1 00000093",
               memRequest, memAddress, fetchDataValid, fetchData);
    end
    fetchRequest = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    mem_rdata = '0;
    countdown = -1;
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_grant_order();
    test_cancel();
    test_cancel_with_response();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
